// File: rtl/fft_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_sequencer_if
// Purpose  : Sequencer <-> butterfly datapath control bundle.
//            FFT_SEQ_INVERSE_EN adds the inverse / tw_conj pair.
// Revision : 1.0  initial release
// ============================================================================
interface fft_sequencer_if #(
  parameter int LOG2_N = 6
);
  logic              start;
  logic              stall;
  logic              load;
  logic [LOG2_N-1:0] idx_a;
  logic [LOG2_N-1:0] idx_b;
  logic [LOG2_N-2:0] tw_idx;
  logic              we;
  logic [2:0]        stage;
  logic              busy;
  logic              done;
`ifdef FFT_SEQ_INVERSE_EN
  logic              inverse;
  logic              tw_conj;
`endif

  // master = sequencer, slave = datapath / requester side
  modport master (
    input  start,
    input  stall,
`ifdef FFT_SEQ_INVERSE_EN
    input  inverse,
    output tw_conj,
`endif
    output load,
    output idx_a,
    output idx_b,
    output tw_idx,
    output we,
    output stage,
    output busy,
    output done
  );

  modport slave (
    output start,
    output stall,
`ifdef FFT_SEQ_INVERSE_EN
    output inverse,
    input  tw_conj,
`endif
    input  load,
    input  idx_a,
    input  idx_b,
    input  tw_idx,
    input  we,
    input  stage,
    input  busy,
    input  done
  );
endinterface
`default_nettype wire

// File: rtl/fft_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_sequencer
// Purpose  : Radix-2 DIT butterfly/stage sequencer for an in-place FFT core.
//            Optional macro FFT_SEQ_INVERSE_EN adds inverse -> tw_conj.
// Revision : 1.0  initial release
// ============================================================================
module fft_sequencer #(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6
) (
  input  logic            clk,
  input  logic            rst,
  fft_sequencer_if.master bus
);
  localparam int            KW         = LOG2_N - 1;
  localparam logic [KW-1:0] K_LAST     = KW'(N_POINTS / 2 - 1);
  localparam logic [2:0]    STAGE_LAST = 3'(LOG2_N - 1);
  localparam logic [3:0]    TW_TOP     = 4'(KW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [2:0]      stage_q, stage_d;

  logic            run;
  logic [KW-1:0]   mask_k;
  logic [KW-1:0]   lo_k;
  logic [LOG2_N-1:0] k_ext;
  logic [LOG2_N-1:0] half;
  logic [LOG2_N-1:0] idx_a_raw;
  logic [3:0]      sh_a;
  logic [3:0]      sh_tw;
  logic [KW-1:0]   tw_raw;

  // State updates follow the datapath, which captures on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_RUN;
        k_d     = '0;
        stage_d = '0;
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (k_q == K_LAST) begin
            k_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = S_DONE;
              stage_d = '0;
            end else begin
              stage_d = stage_q + 3'd1;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Butterfly addressing: insert a zero at bit position `stage` of k for the
  // upper wing; the lower wing sets that bit.
  always_comb begin
    k_ext     = {1'b0, k_q};
    half      = LOG2_N'(1) << stage_q;
    mask_k    = ~({KW{1'b1}} << stage_q);
    lo_k      = k_q & mask_k;
    sh_a      = {1'b0, stage_q} + 4'd1;
    idx_a_raw = ((k_ext >> stage_q) << sh_a) | {1'b0, lo_k};
    sh_tw     = TW_TOP - {1'b0, stage_q};
    tw_raw    = lo_k << sh_tw;
  end

  assign run        = (state_q == S_RUN);
  assign bus.load   = (state_q == S_LOAD);
  assign bus.done   = (state_q == S_DONE);
  assign bus.busy   = (state_q == S_LOAD) || run;
  assign bus.we     = run && !bus.stall;
  assign bus.idx_a  = run ? idx_a_raw : '0;
  assign bus.idx_b  = run ? (idx_a_raw | half) : '0;
  assign bus.tw_idx = run ? tw_raw : '0;
  assign bus.stage  = run ? stage_q : '0;

`ifdef FFT_SEQ_INVERSE_EN
  logic tw_conj_q, tw_conj_d;

  // Direction is latched with the accepted start and dropped once RUN ends.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      tw_conj_q <= 1'b0;
    end else begin
      tw_conj_q <= tw_conj_d;
    end
  end

  always_comb begin
    tw_conj_d = tw_conj_q;
    if (state_q == S_IDLE && bus.start) begin
      tw_conj_d = bus.inverse;
    end else if (state_d == S_IDLE || state_d == S_DONE) begin
      tw_conj_d = 1'b0;
    end
  end

  assign bus.tw_conj = tw_conj_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_sequencer
// Purpose  : Directed self-checking bench for fft_sequencer (64-point).
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_sequencer;
  logic clk = 1'b1;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   we_cnt = 0, load_cnt = 0, done_cnt = 0;
  int   we_base, load_base, done_base;

  fft_sequencer_if #(.LOG2_N(6)) bus();

  fft_sequencer #(.N_POINTS(64), .LOG2_N(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Mid-cycle tally of strobes; inputs only change just after falling edges.
  always @(posedge clk) begin
    we_cnt   += int'(bus.we);
    load_cnt += int'(bus.load);
    done_cnt += int'(bus.done);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc < t) next_cycle();
  endtask

  task automatic settle();
    @(posedge clk);
  endtask

  // Start pulse in cycle 0; returns at the start of cycle 1 with baselines taken.
  task automatic begin_run(input logic inv);
    next_cycle();
    cyc = 0;
    bus.start = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
    bus.inverse = inv;
`else
    if (inv) bus.start = 1'b1;
`endif
    next_cycle();
    bus.start = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    bus.inverse = ~inv;
`endif
    we_base   = we_cnt;
    load_base = load_cnt;
    done_base = done_cnt;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    bus.inverse = 1'b0;
`endif

    // Reset state
    settle();
    check("rst_load", int'(bus.load), 0);
    check("rst_we",   int'(bus.we),   0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_idxa", int'(bus.idx_a), 0);
`ifdef FFT_SEQ_INVERSE_EN
    check("rst_conj", int'(bus.tw_conj), 0);
`endif
    next_cycle();
    rst = 1'b1;
    next_cycle();
    settle();
    check("idle_busy", int'(bus.busy), 0);

    // Run A: plain transform, index spot checks, ignored re-start
    begin_run(1'b1);
    settle();
    check("a1_load",  int'(bus.load),  1);
    check("a1_busy",  int'(bus.busy),  1);
    check("a1_we",    int'(bus.we),    0);
`ifdef FFT_SEQ_INVERSE_EN
    check("a1_conj",  int'(bus.tw_conj), 1);
`endif
    goto_cycle(2);
    settle();
    check("a2_we",    int'(bus.we),    1);
    check("a2_load",  int'(bus.load),  0);
    check("a2_idxa",  int'(bus.idx_a), 0);
    check("a2_idxb",  int'(bus.idx_b), 1);
    goto_cycle(7);
    settle();
    check("s0k5_idxa", int'(bus.idx_a),  10);
    check("s0k5_idxb", int'(bus.idx_b),  11);
    check("s0k5_tw",   int'(bus.tw_idx), 0);
    goto_cycle(50);
    bus.start = 1'b1;
    settle();
    check("a50_busy", int'(bus.busy), 1);
    next_cycle();
    bus.start = 1'b0;
    goto_cycle(73);
    settle();
    check("s2k7_stage", int'(bus.stage),  2);
    check("s2k7_idxa",  int'(bus.idx_a),  11);
    check("s2k7_idxb",  int'(bus.idx_b),  15);
    check("s2k7_tw",    int'(bus.tw_idx), 24);
`ifdef FFT_SEQ_INVERSE_EN
    goto_cycle(100);
    settle();
    check("a100_conj", int'(bus.tw_conj), 1);
`endif
    goto_cycle(167);
    settle();
    check("s5k5_stage", int'(bus.stage),  5);
    check("s5k5_idxa",  int'(bus.idx_a),  5);
    check("s5k5_idxb",  int'(bus.idx_b),  37);
    check("s5k5_tw",    int'(bus.tw_idx), 5);
    goto_cycle(193);
    settle();
    check("a193_we",   int'(bus.we),     1);
    check("a193_idxa", int'(bus.idx_a),  31);
    check("a193_idxb", int'(bus.idx_b),  63);
    check("a193_tw",   int'(bus.tw_idx), 31);
    check("a193_done", int'(bus.done),   0);
`ifdef FFT_SEQ_INVERSE_EN
    check("a193_conj", int'(bus.tw_conj), 1);
`endif
    goto_cycle(194);
    settle();
    check("a194_done", int'(bus.done),  1);
    check("a194_busy", int'(bus.busy),  0);
    check("a194_we",   int'(bus.we),    0);
    check("a194_idxa", int'(bus.idx_a), 0);
`ifdef FFT_SEQ_INVERSE_EN
    check("a194_conj", int'(bus.tw_conj), 0);
`endif
    goto_cycle(195);
    settle();
    check("a195_done", int'(bus.done), 0);
    goto_cycle(201);
    check("a_we_total",   we_cnt - we_base,     192);
    check("a_load_total", load_cnt - load_base, 1);
    check("a_done_total", done_cnt - done_base, 1);

    // Run B: three stall cycles at stage 3, k = 9
    begin_run(1'b0);
    goto_cycle(107);
    bus.stall = 1'b1;
    settle();
    check("st107_stage", int'(bus.stage), 3);
    check("st107_idxa",  int'(bus.idx_a), 17);
    check("st107_idxb",  int'(bus.idx_b), 25);
    check("st107_we",    int'(bus.we),    0);
    goto_cycle(108);
    settle();
    check("st108_idxa", int'(bus.idx_a), 17);
    check("st108_we",   int'(bus.we),    0);
    goto_cycle(109);
    settle();
    check("st109_idxb", int'(bus.idx_b), 25);
    check("st109_we",   int'(bus.we),    0);
    goto_cycle(110);
    bus.stall = 1'b0;
    settle();
    check("st110_we",   int'(bus.we),    1);
    check("st110_idxa", int'(bus.idx_a), 17);
    goto_cycle(111);
    settle();
    check("st111_idxa", int'(bus.idx_a), 18);
    goto_cycle(196);
    settle();
    check("b196_done", int'(bus.done), 0);
    check("b196_busy", int'(bus.busy), 1);
    goto_cycle(197);
    settle();
    check("b197_done", int'(bus.done), 1);
    goto_cycle(198);
    check("b_we_total", we_cnt - we_base, 192);

    // Run C: asynchronous reset mid-transform, then a clean restart
    begin_run(1'b0);
    goto_cycle(100);
    settle();
    check("c100_busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("crst_busy",  int'(bus.busy),  0);
    check("crst_we",    int'(bus.we),    0);
    check("crst_idxa",  int'(bus.idx_a), 0);
    check("crst_idxb",  int'(bus.idx_b), 0);
    check("crst_stage", int'(bus.stage), 0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    check("crel_busy", int'(bus.busy), 0);
    check("crel_load", int'(bus.load), 0);
    begin_run(1'b0);
    settle();
    check("c1_load", int'(bus.load), 1);
    goto_cycle(2);
    settle();
    check("c2_stage", int'(bus.stage), 0);
    check("c2_idxb",  int'(bus.idx_b), 1);
    goto_cycle(7);
    settle();
    check("c7_idxa", int'(bus.idx_a), 10);
    goto_cycle(193);
    settle();
    check("c193_done", int'(bus.done), 0);
    goto_cycle(194);
    settle();
    check("c194_done", int'(bus.done), 1);
    goto_cycle(195);
    check("c_we_total", we_cnt - we_base, 192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter N_POINTS, default 64, meaning FFT length (power of two).
REQ-002 SHALL have parameter LOG2_N, default 6, meaning log2(N_POINTS); both index widths derive from it.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the falling edge, matching the butterfly datapath.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin one transform.
REQ-006 SHALL have port stall  input  1  datapath back-pressure; freezes sequencing.
REQ-007 SHALL have port load  output  1  one-cycle strobe telling the datapath to capture input samples.
REQ-008 SHALL have port idx_a  output  LOG2_N  upper-wing (even) register index of the current butterfly.
REQ-009 SHALL have port idx_b  output  LOG2_N  lower-wing (odd) register index of the current butterfly.
REQ-010 SHALL have port tw_idx  output  LOG2_N-1  twiddle ROM select, 0..N/2-1.
REQ-011 SHALL have port we  output  1  write-back strobe for both wings of the current butterfly.
REQ-012 SHALL have port stage  output  3  current stage number, 0..LOG2_N-1.
REQ-013 SHALL have port busy  output  1  high from the LOAD cycle through the last RUN cycle.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final write-back.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-016 IDLE->LOAD when start=1; LOAD->RUN unconditionally after one cycle; DONE->IDLE after one cycle.
REQ-017 In RUN, butterfly counter k SHALL step 0..N/2-1 per stage; stage SHALL step 0..LOG2_N-1; exactly N/2*LOG2_N = 192 butterflies per transform at default.
REQ-018 For stage s, half=2^s: idx_a = ((k>>s)<<(s+1)) | (k & (half-1)); idx_b = idx_a + half; tw_idx = (k & (half-1)) << (LOG2_N-1-s).
REQ-019 we SHALL be high in every RUN cycle with stall=0, low otherwise; one butterfly is issued per cycle with we.
REQ-020 stall=1 in RUN SHALL hold k, stage, idx_a, idx_b, tw_idx unchanged and force we=0; stall is ignored in IDLE, LOAD, DONE.
REQ-021 On k wrap (N/2-1 -> 0) stage SHALL increment in the same edge; wrap on the last stage SHALL go to DONE.
REQ-022 Latency: start accepted -> load 1 cycle later -> first we 2 cycles later -> done 194 cycles after start with no stalls (each stall cycle adds one).
REQ-023 start while busy or in DONE SHALL be ignored and not queued.
REQ-024 Outside RUN, idx_a, idx_b, tw_idx, stage SHALL read 0.
REQ-025 load SHALL be high exactly in the LOAD state; done exactly in the DONE state.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, k=0, stage=0, and all outputs to 0, including mid-transform.
REQ-027 After rst deassert, the block SHALL wait in IDLE for a fresh start; no partial transform resumes.

Configuration
REQ-028 Macro FFT_SEQ_INVERSE_EN SHALL add input inverse (1 bit) and output tw_conj (1 bit).
REQ-029 With FFT_SEQ_INVERSE_EN defined: inverse is sampled on the accepted start edge and tw_conj holds that value through LOAD and RUN, 0 in IDLE/DONE and after reset.
REQ-030 Without FFT_SEQ_INVERSE_EN: neither port exists; behaviour otherwise identical.

Verification
REQ-031 Reset, start pulse, stall=0 -> load at cycle 1, we high for cycles 2..193, done at cycle 194, busy low in cycle 194.
REQ-032 Full run index check -> stage 0 k=5: idx_a=10, idx_b=11, tw_idx=0; stage 5 k=5: idx_a=5, idx_b=37, tw_idx=5; stage 2 k=7: idx_a=11, idx_b=15, tw_idx=24.
REQ-033 stall high for 3 cycles at stage 3 k=9 -> outputs frozen at idx_a=17, idx_b=25, we=0, done delayed to cycle 197.
REQ-034 start re-pulsed at cycle 50 -> ignored, single done at cycle 194, no second load.
REQ-035 rst low at cycle 100 -> all outputs 0 immediately; new start after release -> full 194-cycle run from stage 0.
REQ-036 With FFT_SEQ_INVERSE_EN, inverse=1 at start then toggled -> tw_conj=1 from cycle 1 through 193, 0 at 194.
